// File: rtl/spiker_adapter_pkg.sv
// Shared types and sizing helpers for the spiker adapter return path.
package spiker_adapter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    ARGMAX,
    WRITE,
    DONE
  } writer_state_t;

  // Number of register-file words needed to hold all packed spike counts.
  function automatic int unsigned n_res_reg(input int unsigned n_out,
                                            input int unsigned cnt_width,
                                            input int unsigned width);
    return (n_out * cnt_width + width - 1) / width;
  endfunction

endpackage

// File: rtl/spiker_writer_if.sv
// Output-spike beat stream from the spiker core into the result writer.
interface spiker_writer_if #(
  parameter int unsigned N_OUT = 10
) ();

  logic             spikes_valid;
  logic [N_OUT-1:0] spikes;
  logic             spikes_ready;

  modport master (output spikes_valid, output spikes, input spikes_ready);
  modport slave  (input spikes_valid, input spikes, output spikes_ready);

endinterface

// File: rtl/spiker_spike_counter.sv
// Bank of per-neuron saturating spike counters with clear and increment enable.
module spiker_spike_counter #(
  parameter int unsigned N_OUT     = 10,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       inc_i,
  input  logic [N_OUT-1:0]           spikes_i,
  output logic [N_OUT*CNT_WIDTH-1:0] cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [N_OUT-1:0][CNT_WIDTH-1:0] cnt_q;
  logic [N_OUT-1:0][CNT_WIDTH-1:0] cnt_d;

  // Next count: clear wins over increment; each neuron sticks at its maximum.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (spikes_i[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spiker_writer.sv
// Spiker adapter return path: accumulates output spikes over one inference,
// picks the winning class by sequential argmax and writes results to hw2reg.
module spiker_writer
  import spiker_adapter_pkg::*;
#(
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned N_OUT     = 10,
  parameter  int unsigned CNT_WIDTH = 8,
  parameter  int unsigned N_STEPS   = 25,
  localparam int unsigned N_RES_REG = n_res_reg(N_OUT, CNT_WIDTH, WIDTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       clear_i,
  spiker_writer_if.slave             spk_if,
  output logic [N_RES_REG*WIDTH-1:0] res_data_o,
  output logic [N_RES_REG-1:0]       res_we_o,
  output logic [$clog2(N_OUT)-1:0]   class_o,
  output logic                       class_we_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       irq_o,
  output logic                       err_o
);

  localparam int unsigned IDX_W  = $clog2(N_OUT);
  localparam int unsigned STEP_W = $clog2(N_STEPS);
  localparam logic [N_RES_REG-1:0] WE_FIRST = N_RES_REG'(1);

  writer_state_t                     state_q;
  logic [STEP_W-1:0]                 step_q;
  logic [IDX_W-1:0]                  idx_q;
  logic [IDX_W-1:0]                  best_q;
  logic [N_RES_REG*WIDTH-1:0]        res_data_q;
  logic [N_RES_REG-1:0]              res_we_q;
  logic [IDX_W-1:0]                  class_q;
  logic                              class_we_q;
  logic                              done_q;
  logic                              irq_q;
  logic                              err_q;

  logic [N_OUT*CNT_WIDTH-1:0]        cnt_vec;
  logic [N_OUT-1:0][CNT_WIDTH-1:0]   cnt_arr;
  logic [CNT_WIDTH-1:0]              cur_cnt;
  logic [CNT_WIDTH-1:0]              best_cnt;
  logic [IDX_W-1:0]                  idx_win;
  logic [N_RES_REG-1:0]              we_shift;
  logic                              busy;
  logic                              accept;
  logic                              start_ok;

  assign busy     = (state_q == ACCUM) || (state_q == ARGMAX) || (state_q == WRITE);
  assign accept   = (state_q == ACCUM) && spk_if.spikes_valid;
  assign start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));

  spiker_spike_counter #(
    .N_OUT     (N_OUT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (start_ok),
    .inc_i    (accept),
    .spikes_i (spk_if.spikes),
    .cnt_o    (cnt_vec)
  );

  assign cnt_arr = cnt_vec;

  // Select the counts under scan and the current best without variable part-selects.
  always_comb begin
    cur_cnt  = '0;
    best_cnt = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (idx_q == IDX_W'(i)) cur_cnt = cnt_arr[i];
      if (best_q == IDX_W'(i)) best_cnt = cnt_arr[i];
    end
  end

  // Strictly-greater replacement keeps the lowest index on ties.
  assign idx_win  = (cur_cnt > best_cnt) ? idx_q : best_q;
  assign we_shift = res_we_q << 1;

  // Control FSM with argmax scan and write sequencer; all outputs registered.
  // The write strobe is a one-hot walker: WRITE ends when it leaves the top bit,
  // and the class strobe fires alongside the last register strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      step_q     <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      res_data_q <= '0;
      res_we_q   <= '0;
      class_q    <= '0;
      class_we_q <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (clear_i) begin
        err_q <= 1'b0;
      end else if (start_i && busy) begin
        err_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ACCUM;
            step_q  <= '0;
          end
        end
        ACCUM: begin
          if (spk_if.spikes_valid) begin
            if (step_q == STEP_W'(N_STEPS - 1)) begin
              state_q <= ARGMAX;
              step_q  <= '0;
              idx_q   <= '0;
              best_q  <= '0;
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
        end
        ARGMAX: begin
          best_q <= idx_win;
          if (idx_q == IDX_W'(N_OUT - 1)) begin
            state_q    <= WRITE;
            res_data_q <= (N_RES_REG*WIDTH)'(cnt_vec);
            res_we_q   <= WE_FIRST;
            class_q    <= idx_win;
            class_we_q <= WE_FIRST[N_RES_REG-1];
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        WRITE: begin
          res_we_q   <= we_shift;
          class_we_q <= we_shift[N_RES_REG-1];
          if (res_we_q[N_RES_REG-1]) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            irq_q   <= 1'b1;
          end
        end
        DONE: begin
          if (start_i) begin
            state_q <= ACCUM;
            step_q  <= '0;
            done_q  <= 1'b0;
          end else if (clear_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spk_if.spikes_ready = (state_q == ACCUM);
  assign res_data_o          = res_data_q;
  assign res_we_o            = res_we_q;
  assign class_o             = class_q;
  assign class_we_o          = class_we_q;
  assign busy_o              = busy;
  assign done_o              = done_q;
  assign irq_o               = irq_q;
  assign err_o               = err_q;

endmodule

// File: tb/tb_spiker_writer.sv
// Self-checking bench for spiker_writer: default instance plus a 4-bit counter instance.
module tb_spiker_writer;

  localparam int NO    = 10;
  localparam int NS    = 25;
  localparam int NR_A  = 3;
  localparam int NR_B  = 2;
  localparam int LAT_A = NO + NR_A + 1;
  localparam int LAT_B = NO + NR_B + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                start_a, clear_a, start_b, clear_b;
  logic [NR_A*32-1:0]  res_data_a;
  logic [NR_A-1:0]     res_we_a;
  logic [3:0]          class_a;
  logic                class_we_a, busy_a, done_a, irq_a, err_a;
  logic [NR_B*32-1:0]  res_data_b;
  logic [NR_B-1:0]     res_we_b;
  logic [3:0]          class_b;
  logic                class_we_b, busy_b, done_b, irq_b, err_b;

  spiker_writer_if #(.N_OUT(NO)) if_a ();
  spiker_writer_if #(.N_OUT(NO)) if_b ();

  spiker_writer dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .clear_i(clear_a), .spk_if(if_a),
    .res_data_o(res_data_a), .res_we_o(res_we_a), .class_o(class_a), .class_we_o(class_we_a),
    .busy_o(busy_a), .done_o(done_a), .irq_o(irq_a), .err_o(err_a)
  );

  spiker_writer #(.CNT_WIDTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .clear_i(clear_b), .spk_if(if_b),
    .res_data_o(res_data_b), .res_we_o(res_we_b), .class_o(class_b), .class_we_o(class_we_b),
    .busy_o(busy_b), .done_o(done_b), .irq_o(irq_b), .err_o(err_b)
  );

  int checks = 0;
  int errors = 0;

  logic [NO-1:0] beats [NS];

  // Strobe monitor for instance A.
  int we_cnt_a [NR_A];
  int irq_cnt_a = 0;
  int cwe_cnt_a = 0;
  int multi_we_a = 0;
  logic [3:0] class_at_we_a = '0;
  logic cwe_on_last_a = 1'b0;
  initial for (int r = 0; r < NR_A; r++) we_cnt_a[r] = 0;
  always @(negedge clk) begin
    for (int r = 0; r < NR_A; r++) if (res_we_a[r]) we_cnt_a[r]++;
    if ($countones(res_we_a) > 1) multi_we_a++;
    if (irq_a) irq_cnt_a++;
    if (class_we_a) begin
      cwe_cnt_a++;
      class_at_we_a = class_a;
      cwe_on_last_a = res_we_a[NR_A-1];
    end
  end

  // Reference: total spikes per neuron, clipped, then first maximum wins.
  task automatic model(input int cw, output logic [95:0] ed, output int ec);
    int cnt, maxc, bestv;
    maxc = (1 << cw) - 1;
    ed = '0; ec = 0; bestv = -1;
    for (int i = 0; i < NO; i++) begin
      cnt = 0;
      for (int s = 0; s < NS; s++) cnt += int'(beats[s][i]);
      if (cnt > maxc) cnt = maxc;
      if (cnt > bestv) begin bestv = cnt; ec = i; end
      for (int b = 0; b < cw; b++) ed[i*cw + b] = 1'(cnt >> b);
    end
  endtask

  task automatic run_a(input bit gaps, input bit mid_start, input string name);
    logic [95:0] ed;
    int ec, n, i0, c0, m0;
    int w0 [NR_A];
    model(8, ed, ec);
    for (int r = 0; r < NR_A; r++) w0[r] = we_cnt_a[r];
    i0 = irq_cnt_a; c0 = cwe_cnt_a; m0 = multi_we_a;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int s = 0; s < NS; s++) begin
      while (gaps && ($urandom_range(1) == 0)) begin
        if_a.spikes_valid = 1'b0; if_a.spikes = NO'($urandom);
        checks++;
        if (if_a.spikes_ready !== 1'b1) begin
          errors++; $display("FAIL %s ready_in_gap got %b want 1", name, if_a.spikes_ready);
        end
        @(negedge clk);
      end
      if (mid_start && s == 12) start_a = 1'b1;
      if_a.spikes_valid = 1'b1; if_a.spikes = beats[s];
      checks++;
      if (if_a.spikes_ready !== 1'b1) begin
        errors++; $display("FAIL %s ready_accum got %b want 1", name, if_a.spikes_ready);
      end
      @(negedge clk);
      start_a = 1'b0;
    end
    n = 1;
    while (!done_a && n < 40) begin
      checks++;
      if (if_a.spikes_ready !== 1'b0) begin
        errors++; $display("FAIL %s ready_after_accum got %b want 0 at n=%0d", name, if_a.spikes_ready, n);
      end
      if_a.spikes_valid = 1'($urandom); if_a.spikes = NO'($urandom);
      @(negedge clk);
      n++;
    end
    if_a.spikes_valid = 1'b0;
    checks++;
    if (n !== LAT_A) begin errors++; $display("FAIL %s done_latency got %0d want %0d", name, n, LAT_A); end
    checks++;
    if (res_data_a !== ed) begin errors++; $display("FAIL %s res_data got %h want %h", name, res_data_a, ed); end
    checks++;
    if (class_a !== 4'(ec)) begin errors++; $display("FAIL %s class got %0d want %0d", name, class_a, ec); end
    checks++;
    if (err_a !== mid_start) begin errors++; $display("FAIL %s err got %b want %b", name, err_a, mid_start); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL %s busy_in_done got %b want 0", name, busy_a); end
    @(negedge clk);
    for (int r = 0; r < NR_A; r++) begin
      checks++;
      if (we_cnt_a[r] - w0[r] !== 1) begin
        errors++; $display("FAIL %s res_we%0d_pulses got %0d want 1", name, r, we_cnt_a[r] - w0[r]);
      end
    end
    checks++;
    if (multi_we_a - m0 !== 0) begin errors++; $display("FAIL %s res_we_onehot got %0d multi want 0", name, multi_we_a - m0); end
    checks++;
    if (cwe_cnt_a - c0 !== 1 || class_at_we_a !== 4'(ec) || cwe_on_last_a !== 1'b1) begin
      errors++; $display("FAIL %s class_we got pulses=%0d class=%0d last=%b want 1/%0d/1",
                         name, cwe_cnt_a - c0, class_at_we_a, cwe_on_last_a, ec);
    end
    checks++;
    if (irq_cnt_a - i0 !== 1 || irq_a !== 1'b0 || done_a !== 1'b1) begin
      errors++; $display("FAIL %s irq_done got irq_pulses=%0d irq=%b done=%b want 1/0/1",
                         name, irq_cnt_a - i0, irq_a, done_a);
    end
    clear_a = 1'b1;
    @(negedge clk); clear_a = 1'b0;
    checks++;
    if (done_a !== 1'b0 || err_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL %s after_clear got done=%b err=%b busy=%b want 0/0/0", name, done_a, err_a, busy_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if_a.spikes_valid = 1'b1; if_a.spikes = '1;
      @(negedge clk);
      checks++;
      if (if_a.spikes_ready !== 1'b0) begin errors++; $display("FAIL reset ready_idle got %b want 0", if_a.spikes_ready); end
    end
    if_a.spikes_valid = 1'b0;
    checks++;
    if ({res_data_a, res_we_a, class_a, class_we_a, busy_a, done_a, irq_a, err_a} !== '0) begin
      errors++; $display("FAIL reset outputs_a got data=%h we=%b cls=%0d busy=%b done=%b irq=%b err=%b want 0",
                         res_data_a, res_we_a, class_a, busy_a, done_a, irq_a, err_a);
    end
    checks++;
    if ({res_data_b, res_we_b, class_b, class_we_b, busy_b, done_b, irq_b, err_b, if_b.spikes_ready} !== '0) begin
      errors++; $display("FAIL reset outputs_b got data=%h done=%b busy=%b want 0", res_data_b, done_b, busy_b);
    end
  endtask

  task automatic fill_basic();
    for (int s = 0; s < NS; s++) beats[s] = NO'((1 << 3) | ((s % 2 == 0) ? (1 << 7) : 0));
  endtask

  task automatic test_basic();
    fill_basic();
    run_a(1'b0, 1'b0, "basic");
    checks++;
    if (res_data_a[95:0] !== {32'h0, 32'h0D000000, 32'h19000000}) begin
      errors++; $display("FAIL basic_regs got %h want 00000000_0D000000_19000000", res_data_a);
    end
  endtask

  task automatic test_tie();
    for (int s = 0; s < NS; s++) beats[s] = NO'((1 << 2) | (1 << 5));
    run_a(1'b0, 1'b0, "tie");
  endtask

  task automatic test_gaps();
    fill_basic();
    run_a(1'b1, 1'b0, "gaps_basic");
    for (int s = 0; s < NS; s++) beats[s] = NO'($urandom);
    run_a(1'b1, 1'b0, "gaps_random");
  endtask

  task automatic test_err();
    fill_basic();
    run_a(1'b0, 1'b1, "mid_start");
  endtask

  task automatic test_saturation();
    int n;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if_b.spikes_valid = 1'b1; if_b.spikes = '1;
      @(negedge clk);
    end
    if_b.spikes_valid = 1'b0;
    n = 1;
    while (!done_b && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n !== LAT_B) begin errors++; $display("FAIL sat done_latency got %0d want %0d", n, LAT_B); end
    checks++;
    if (res_data_b !== 64'h000000FF_FFFFFFFF) begin
      errors++; $display("FAIL sat res_data got %h want 000000ffffffffff", res_data_b);
    end
    checks++;
    if (class_b !== 4'd0) begin errors++; $display("FAIL sat class got %0d want 0", class_b); end
    clear_b = 1'b1;
    @(negedge clk); clear_b = 1'b0;
  endtask

  task automatic test_mid_reset();
    int w0 [NR_A];
    int i0;
    for (int r = 0; r < NR_A; r++) w0[r] = we_cnt_a[r];
    i0 = irq_cnt_a;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int s = 0; s < 10; s++) begin
      if_a.spikes_valid = 1'b1; if_a.spikes = '1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || if_a.spikes_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset state got busy=%b ready=%b want 0/0", busy_a, if_a.spikes_ready);
    end
    repeat (30) @(negedge clk);
    if_a.spikes_valid = 1'b0;
    checks++;
    if ({res_data_a, res_we_a, class_a, done_a, err_a} !== '0) begin
      errors++; $display("FAIL mid_reset outputs got data=%h done=%b err=%b want 0", res_data_a, done_a, err_a);
    end
    for (int r = 0; r < NR_A; r++) begin
      checks++;
      if (we_cnt_a[r] !== w0[r]) begin
        errors++; $display("FAIL mid_reset res_we%0d got %0d pulses want 0", r, we_cnt_a[r] - w0[r]);
      end
    end
    checks++;
    if (irq_cnt_a !== i0) begin errors++; $display("FAIL mid_reset irq got %0d pulses want 0", irq_cnt_a - i0); end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; clear_a = 1'b0; start_b = 1'b0; clear_b = 1'b0;
    if_a.spikes_valid = 1'b0; if_a.spikes = '0;
    if_b.spikes_valid = 1'b0; if_b.spikes = '0;
    test_reset();
    test_basic();
    test_tie();
    test_gaps();
    test_err();
    test_saturation();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
